// File: rtl/trace_capture_ctrl_if.sv
// Control/status bundle for trace_capture_ctrl.
// slave: the capture controller. master: the side that drives arm/abort/triggers/data.
interface trace_capture_ctrl_if #(
    parameter int unsigned pCOUNT_WIDTH = 16
);
    logic                    I_arm;
    logic                    I_abort;
    logic                    I_trig_sel;
    logic                    I_match_trig;
    logic                    I_m3_trig;
    logic [pCOUNT_WIDTH-1:0] I_capture_len;
    logic                    I_data_valid;
    logic                    I_fifo_full;
    logic                    O_fifo_wr;
    logic                    O_arm;
    logic                    O_capturing;
    logic                    O_done;
    logic                    O_overflow;
    logic                    O_timeout;
    logic                    O_trig_out;
    logic [pCOUNT_WIDTH-1:0] O_count;

    modport master (
        output I_arm, I_abort, I_trig_sel, I_match_trig, I_m3_trig,
               I_capture_len, I_data_valid, I_fifo_full,
        input  O_fifo_wr, O_arm, O_capturing, O_done, O_overflow,
               O_timeout, O_trig_out, O_count
    );

    modport slave (
        input  I_arm, I_abort, I_trig_sel, I_match_trig, I_m3_trig,
               I_capture_len, I_data_valid, I_fifo_full,
        output O_fifo_wr, O_arm, O_capturing, O_done, O_overflow,
               O_timeout, O_trig_out, O_count
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: arm, wait for a trigger edge, stream up to
// I_capture_len words into the capture FIFO (0 = unlimited), then DONE.
// Optional build macro TRIG_TIMEOUT_EN adds an ARMED-state trigger timeout
// of pTIMEOUT cycles; without it O_timeout is tied low.
module trace_capture_ctrl #(
    parameter int unsigned pCOUNT_WIDTH = 16,
    parameter int unsigned pTIMEOUT     = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    trace_capture_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    trig_now;
    logic                    trig_prev;
    logic                    trig_rise;
    logic                    fifo_wr;
    logic                    last_wr;
    logic                    arm_ok;
    logic                    trig_ok;
    logic                    timeout_hit;
    logic [pCOUNT_WIDTH-1:0] count;
    logic [pCOUNT_WIDTH-1:0] cap_len;
    logic                    overflow;
    logic                    trig_out;

    assign trig_now  = bus.I_trig_sel ? bus.I_m3_trig : bus.I_match_trig;
    assign trig_rise = trig_now & ~trig_prev;
    assign fifo_wr   = (state == CAPTURE) & bus.I_data_valid & ~bus.I_fifo_full;
    assign last_wr   = fifo_wr && (cap_len != '0) &&
                       (count == cap_len - pCOUNT_WIDTH'(1));

`ifdef TRIG_TIMEOUT_EN
    localparam int unsigned TIMER_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;

    logic [TIMER_W-1:0] timer;
    logic               timeout_flag;

    // Count cycles spent in ARMED; held at zero everywhere else so entry clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ARMED) begin
            timer <= timer + TIMER_W'(1);
        end else begin
            timer <= '0;
        end
    end

    // A trigger edge in the expiry cycle takes precedence over the timeout.
    assign timeout_hit = (state == ARMED) && !trig_rise &&
                         (timer == TIMER_W'(pTIMEOUT - 1));

    // Sticky timeout flag, cleared by an accepted arm; abort suppresses setting it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (arm_ok) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit && !bus.I_abort) begin
            timeout_flag <= 1'b1;
        end
    end

    assign bus.O_timeout = timeout_flag;
`else
    assign timeout_hit   = 1'b0;
    assign bus.O_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides arm, trigger and the final write.
    always_comb begin
        state_nxt = state;
        arm_ok    = 1'b0;
        trig_ok   = 1'b0;
        if (bus.I_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.I_arm) begin
                        state_nxt = ARMED;
                        arm_ok    = 1'b1;
                    end
                end
                ARMED: begin
                    if (trig_rise) begin
                        state_nxt = CAPTURE;
                        trig_ok   = 1'b1;
                    end else if (timeout_hit) begin
                        state_nxt = IDLE;
                    end
                end
                CAPTURE: begin
                    if (last_wr) begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Trigger history, word counter, sticky overflow and sampled capture length.
    // The write count advances even on an aborted final write, since the word is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_prev <= 1'b0;
            trig_out  <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
            cap_len   <= '0;
        end else begin
            trig_prev <= trig_now;
            trig_out  <= trig_ok;
            if (arm_ok) begin
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (fifo_wr && (count != '1)) begin
                    count <= count + pCOUNT_WIDTH'(1);
                end
                if ((state == CAPTURE) && bus.I_data_valid && bus.I_fifo_full) begin
                    overflow <= 1'b1;
                end
            end
            if (trig_ok) begin
                cap_len <= bus.I_capture_len;
            end
        end
    end

    assign bus.O_fifo_wr   = fifo_wr;
    assign bus.O_arm       = (state == ARMED);
    assign bus.O_capturing = (state == CAPTURE);
    assign bus.O_done      = (state == DONE);
    assign bus.O_overflow  = overflow;
    assign bus.O_trig_out  = trig_out;
    assign bus.O_count     = count;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a flag-based behavioural model.
module tb_trace_capture_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned TMO  = 10;
    localparam int          MAXC = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    trace_capture_ctrl_if #(.pCOUNT_WIDTH(W)) bus ();

    trace_capture_ctrl #(
        .pCOUNT_WIDTH(W),
        .pTIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: which phase we are in as independent flags, plus plain counters.
    bit m_armed, m_capt, m_done, m_ovf, m_tmo, m_trig, m_prev;
    int m_count, m_len, m_tcyc;

    int wr_seen, trig_seen, done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_wr();
        return m_capt && bus.I_data_valid && !bus.I_fifo_full;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_capt = 0; m_done = 0;
        m_ovf = 0; m_tmo = 0; m_trig = 0; m_prev = 0;
        m_count = 0; m_len = 0; m_tcyc = 0;
    endtask

    task automatic model_step();
        bit sel_now, rise, wr;
        sel_now = bus.I_trig_sel ? bus.I_m3_trig : bus.I_match_trig;
        rise    = sel_now && !m_prev;
        wr      = model_wr();
        m_trig  = 0;
        if (wr) m_count = (m_count < MAXC) ? m_count + 1 : MAXC;
        if (m_capt && bus.I_data_valid && bus.I_fifo_full) m_ovf = 1;
        if (bus.I_abort) begin
            m_armed = 0; m_capt = 0; m_done = 0;
        end else if (!m_armed && !m_capt && bus.I_arm) begin
            m_armed = 1; m_done = 0;
            m_count = 0; m_ovf = 0; m_tmo = 0; m_tcyc = 0;
        end else if (m_armed) begin
            if (rise) begin
                m_armed = 0; m_capt = 1; m_trig = 1;
                m_len = int'(bus.I_capture_len);
            end else begin
                m_tcyc++;
`ifdef TRIG_TIMEOUT_EN
                if (m_tcyc == TMO) begin
                    m_armed = 0; m_tmo = 1;
                end
`endif
            end
        end else if (m_capt && wr && m_len != 0 && m_count == m_len) begin
            m_capt = 0; m_done = 1;
        end
        m_prev = sel_now;
    endtask

    task automatic check_outputs();
        check("flags", {bus.O_arm, bus.O_capturing, bus.O_done, bus.O_overflow,
                        bus.O_timeout, bus.O_trig_out},
                       {m_armed, m_capt, m_done, m_ovf, m_tmo, m_trig});
        check("count", bus.O_count, m_count[W-1:0]);
    endtask

    // One clock: check the combinational write strobe, advance the model, check state.
    task automatic tick();
        #1;
        check("fifo_wr", bus.O_fifo_wr, model_wr());
        if (bus.O_fifo_wr === 1'b1) wr_seen++;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        if (bus.O_trig_out === 1'b1) trig_seen++;
        if (bus.O_done === 1'b1) done_seen++;
    endtask

    initial begin
        reset = 1'b1;
        bus.I_arm = 0; bus.I_abort = 0; bus.I_trig_sel = 0;
        bus.I_match_trig = 0; bus.I_m3_trig = 0; bus.I_capture_len = '0;
        bus.I_data_valid = 0; bus.I_fifo_full = 0;
        wr_seen = 0; trig_seen = 0; done_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("reset_wr", bus.O_fifo_wr, 1'b0);
        reset = 1'b0;

        // Match-edge capture of 4 words; arm on the first edge after reset.
        bus.I_capture_len = 4'd4;
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        check("arm_first_edge", bus.O_arm, 1'b1);
        wr_seen = 0; trig_seen = 0;
        bus.I_match_trig = 1; tick();
        bus.I_data_valid = 1;
        repeat (6) tick();
        check("match_writes", wr_seen, 4);
        check("match_trig_pulses", trig_seen, 1);
        check("match_done", bus.O_done, 1'b1);
        check("match_count", bus.O_count, 4'd4);
        check("match_ovf", bus.O_overflow, 1'b0);

        // Trigger level already high at arm must not fire; then FIFO-full stall.
        bus.I_data_valid = 0; bus.I_match_trig = 0;
        bus.I_trig_sel = 1; bus.I_m3_trig = 1; tick();
        bus.I_capture_len = 4'd5;
        trig_seen = 0;
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        repeat (3) tick();
        check("level_stays_armed", bus.O_arm, 1'b1);
        check("level_no_trig", trig_seen, 0);
        bus.I_m3_trig = 0; tick();
        bus.I_m3_trig = 1; tick();
        check("m3_capture", bus.O_capturing, 1'b1);
        bus.I_capture_len = 4'd2;
        bus.I_data_valid = 1; wr_seen = 0;
        repeat (2) tick();
        bus.I_fifo_full = 1;
        repeat (3) tick();
        check("full_no_writes", wr_seen, 2);
        bus.I_fifo_full = 0;
        repeat (5) tick();
        check("full_writes", wr_seen, 5);
        check("full_ovf", bus.O_overflow, 1'b1);
        check("full_done", bus.O_done, 1'b1);
        check("full_count", bus.O_count, 4'd5);

        // Abort together with arm in DONE.
        bus.I_data_valid = 0;
        bus.I_arm = 1; bus.I_abort = 1; tick();
        bus.I_arm = 0; bus.I_abort = 0;
        check("abort_arm_idle", {bus.O_arm, bus.O_capturing, bus.O_done}, 3'b000);

        // Abort on the final write: the word is written, DONE never appears.
        bus.I_capture_len = 4'd3;
        bus.I_m3_trig = 0;
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        bus.I_m3_trig = 1; tick();
        bus.I_data_valid = 1; wr_seen = 0; done_seen = 0;
        repeat (2) tick();
        bus.I_abort = 1; tick(); bus.I_abort = 0;
        bus.I_data_valid = 0;
        repeat (2) tick();
        check("abort_last_writes", wr_seen, 3);
        check("abort_last_count", bus.O_count, 4'd3);
        check("abort_last_no_done", done_seen, 0);
        check("abort_last_idle", {bus.O_arm, bus.O_capturing, bus.O_done}, 3'b000);

        // No trigger after arm: timeout build leaves ARMED after exactly TMO cycles.
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        repeat (TMO - 1) tick();
        check("tmo_still_armed", bus.O_arm, 1'b1);
        tick();
`ifdef TRIG_TIMEOUT_EN
        check("tmo_idle", bus.O_arm, 1'b0);
        check("tmo_flag", bus.O_timeout, 1'b1);
`else
        check("no_tmo_armed", bus.O_arm, 1'b1);
        check("no_tmo_flag", bus.O_timeout, 1'b0);
`endif
        repeat (3) tick();
        bus.I_abort = 1; tick(); bus.I_abort = 0;

        // Asynchronous reset in the middle of a capture, then re-arm.
        bus.I_trig_sel = 0; bus.I_match_trig = 0; bus.I_capture_len = 4'd6;
        tick();
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        bus.I_match_trig = 1; tick();
        bus.I_data_valid = 1;
        repeat (2) tick();
        check("pre_reset_count", bus.O_count, 4'd2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("async_reset_wr", bus.O_fifo_wr, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.I_data_valid = 0; bus.I_match_trig = 0;
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        bus.I_match_trig = 1; tick();
        bus.I_data_valid = 1;
        repeat (8) tick();
        check("rearm_done", bus.O_done, 1'b1);
        check("rearm_count", bus.O_count, 4'd6);

        // Unlimited length: counter saturates at all-ones and never finishes.
        bus.I_data_valid = 0; bus.I_match_trig = 0; bus.I_capture_len = '0;
        bus.I_arm = 1; tick(); bus.I_arm = 0;
        bus.I_match_trig = 1; tick();
        bus.I_data_valid = 1; done_seen = 0;
        repeat (MAXC + 5) tick();
        check("sat_count", bus.O_count, MAXC[W-1:0]);
        check("sat_capturing", bus.O_capturing, 1'b1);
        check("sat_no_done", done_seen, 0);
        bus.I_abort = 1; tick(); bus.I_abort = 0;

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bus.I_arm          = ($urandom_range(0, 7) == 0);
            bus.I_abort        = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 31) == 0) bus.I_trig_sel = ~bus.I_trig_sel;
            if ($urandom_range(0, 3) == 0)  bus.I_match_trig = ~bus.I_match_trig;
            if ($urandom_range(0, 3) == 0)  bus.I_m3_trig = ~bus.I_m3_trig;
            bus.I_capture_len  = W'($urandom_range(0, 7));
            bus.I_data_valid   = ($urandom_range(0, 3) != 0);
            bus.I_fifo_full    = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
